uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: bus-attached 8N1 UART transmitter with a small transmit FIFO.
// Bus writes are accepted in one cycle with no stall. A write to a full FIFO,
// or any read, is flagged combinationally on uart_error in the same cycle.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_cen,
  input  logic       uart_wr,
  input  logic [7:0] uart_wdata,
  output logic       uart_error,
  output logic       tx,
  output logic       tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic bit_end;

  // Fullness is judged on the pre-edge count, so a same-edge pop never makes room.
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = uart_cen & uart_wr & ~fifo_full;
  assign uart_error = uart_cen & (~uart_wr | fifo_full);
  assign bit_end    = (baud_cnt == BAUD_LAST);

  // Pop when idle with data waiting, or at the end of a stop bit to chain frames.
  assign pop     = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign tx_busy = (state != S_IDLE) | ~fifo_empty;

  // FIFO storage: data only, no reset needed since count guards validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= uart_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: start, eight data bits LSB first, stop; each bit CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            bit_idx   <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              bit_idx   <= '0;
              state     <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Registered serial output derived from the current state, so tx never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= 1'b1;
    end else begin
      case (state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shift_reg[0];
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// Accepted bytes are queued when written; a serial monitor decodes every frame
// on tx, sampling each cycle, and compares it against the head of the queue.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       uart_cen   = 1'b0;
  logic       uart_wr    = 1'b0;
  logic [7:0] uart_wdata = 8'h00;
  logic       uart_error;
  logic       tx;
  logic       tx_busy;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  time        start_q[$];
  time        write_time;
  int         frames_done = 0;

  logic       mon_active = 1'b0;
  logic       mon_skip   = 1'b0;
  logic       mon_bad    = 1'b0;
  int         mon_cnt    = 0;
  logic [9:0] mon_frame  = '1;
  logic [7:0] mon_got    = '0;

  uart_tx #(
    .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_cen(uart_cen),
    .uart_wr(uart_wr),
    .uart_wdata(uart_wdata),
    .uart_error(uart_error),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Serial monitor: detect a start bit, check every sample of the 40-cycle frame
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_bad    = 1'b0;
        mon_got    = '0;
        start_q.push_back($time);
        checks++;
        if (exp_q.size() == 0) begin
          mon_skip  = 1'b1;
          mon_frame = 10'b1_0000_0000_0;
          $display("[TB] FAIL unexpected_frame: tx low at %0t with nothing queued, required tx=1", $time);
        end else begin
          passes++;
          mon_skip  = 1'b0;
          mon_frame = {1'b1, exp_q.pop_front(), 1'b0};
        end
      end
      if (mon_active) begin
        if (tx !== mon_frame[mon_cnt / CLK_DIV]) mon_bad = 1'b1;
        if (mon_cnt >= CLK_DIV && mon_cnt < 9 * CLK_DIV && (mon_cnt % CLK_DIV) == CLK_DIV / 2)
          mon_got[mon_cnt / CLK_DIV - 1] = tx;
        mon_cnt++;
        if (mon_cnt == FRAME) begin
          mon_active = 1'b0;
          frames_done++;
          if (!mon_skip) begin
            checks++;
            if (mon_bad || mon_got !== mon_frame[8:1])
              $display("[TB] FAIL frame: got byte 0x%02h (bit timing bad=%0b), required 0x%02h with exact 4-cycle bits",
                       mon_got, mon_bad, mon_frame[8:1]);
            else
              passes++;
          end
        end
      end
    end
  end

  // Watchdog so the bench always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [7:0] b, input logic exp_err, input string tag);
    @(negedge clk);
    uart_cen   = 1'b1;
    uart_wr    = 1'b1;
    uart_wdata = b;
    #1;
    checks++;
    if (uart_error !== exp_err)
      $display("[TB] FAIL %s: uart_error=%b, required %b", tag, uart_error, exp_err);
    else
      passes++;
    if (!exp_err) exp_q.push_back(b);
    @(posedge clk);
    write_time = $time;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    uart_cen = 1'b0;
    uart_wr  = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    checks++;
    if (frames_done < target)
      $display("[TB] FAIL %s: frames seen=%0d, required %0d within %0d cycles", tag, frames_done, target, budget);
    else
      passes++;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    uart_cen = 1'b0;
    #12;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("[TB] FAIL reset_outputs: tx=%b tx_busy=%b, required tx=1 tx_busy=0", tx, tx_busy);
    else
      passes++;
    uart_cen = 1'b1;
    uart_wr  = 1'b0;
    #1;
    checks++;
    if (uart_error !== 1'b1)
      $display("[TB] FAIL reset_error_comb: uart_error=%b, required 1", uart_error);
    else
      passes++;
    uart_cen = 1'b0;
    #1;
    checks++;
    if (uart_error !== 1'b0)
      $display("[TB] FAIL reset_error_idle: uart_error=%b, required 0", uart_error);
    else
      passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("[TB] FAIL post_reset_idle: tx=%b tx_busy=%b, required tx=1 tx_busy=0", tx, tx_busy);
    else
      passes++;
  endtask

  task automatic test_single_write();
    int f0 = frames_done;
    time dt;
    start_q.delete();
    bus_write(8'hA5, 1'b0, "single_error");
    bus_idle();
    wait_frames(f0 + 1, 80, "single_frame");
    dt = (start_q.size() > 0) ? start_q[0] - write_time : 0;
    checks++;
    if (dt != 25)
      $display("[TB] FAIL single_latency: start bit seen %0t after write edge, required 25", dt);
    else
      passes++;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("[TB] FAIL single_idle_after: tx=%b tx_busy=%b, required tx=1 tx_busy=0", tx, tx_busy);
    else
      passes++;
  endtask

  task automatic test_back_to_back();
    int f0 = frames_done;
    time gap;
    start_q.delete();
    bus_write(8'h00, 1'b0, "b2b_error_0");
    bus_write(8'hFF, 1'b0, "b2b_error_1");
    bus_idle();
    wait_frames(f0 + 2, 150, "b2b_frames");
    gap = (start_q.size() == 2) ? start_q[1] - start_q[0] : 0;
    checks++;
    if (gap != 400)
      $display("[TB] FAIL b2b_gap: frame starts %0t apart (starts=%0d), required 400", gap, start_q.size());
    else
      passes++;
  endtask

  task automatic test_overflow();
    int f0 = frames_done;
    for (int i = 1; i <= 6; i++)
      bus_write(8'(i), (i == 6), $sformatf("overflow_error_%0d", i));
    bus_idle();
    wait_frames(f0 + 5, 5 * FRAME + 60, "overflow_frames");
    repeat (80) @(negedge clk);
    checks++;
    if (frames_done != f0 + 5 || exp_q.size() != 0)
      $display("[TB] FAIL overflow_count: frames=%0d pending=%0d, required frames=5 pending=0",
               frames_done - f0, exp_q.size());
    else
      passes++;
  endtask

  task automatic test_read_unselected();
    int f0 = frames_done;
    @(negedge clk);
    uart_cen   = 1'b1;
    uart_wr    = 1'b0;
    uart_wdata = 8'h77;
    #1;
    checks++;
    if (uart_error !== 1'b1)
      $display("[TB] FAIL read_error: uart_error=%b, required 1", uart_error);
    else
      passes++;
    @(negedge clk);
    uart_cen   = 1'b0;
    uart_wr    = 1'b1;
    uart_wdata = 8'h55;
    #1;
    checks++;
    if (uart_error !== 1'b0)
      $display("[TB] FAIL unselected_error: uart_error=%b, required 0", uart_error);
    else
      passes++;
    bus_idle();
    repeat (60) @(negedge clk);
    checks++;
    if (frames_done != f0 || tx !== 1'b1 || tx_busy !== 1'b0)
      $display("[TB] FAIL read_unselected_quiet: frames=%0d tx=%b tx_busy=%b, required 0 1 0",
               frames_done - f0, tx, tx_busy);
    else
      passes++;
  endtask

  task automatic test_reset_mid_frame();
    int f0 = frames_done;
    int lows = 0;
    bus_write(8'h00, 1'b0, "midrst_error_0");
    bus_write(8'hC3, 1'b0, "midrst_error_1");
    bus_write(8'h81, 1'b0, "midrst_error_2");
    bus_idle();
    repeat (17) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1)
      $display("[TB] FAIL midrst_before: tx=%b tx_busy=%b in data bit 3, required tx=0 tx_busy=1", tx, tx_busy);
    else
      passes++;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("[TB] FAIL midrst_async: tx=%b tx_busy=%b, required tx=1 tx_busy=0", tx, tx_busy);
    else
      passes++;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || tx_busy !== 1'b0 || frames_done != f0)
      $display("[TB] FAIL midrst_flushed: tx low samples=%0d tx_busy=%b frames=%0d, required 0 0 0",
               lows, tx_busy, frames_done - f0);
    else
      passes++;
  endtask

  task automatic test_pointer_wrap();
    int f0 = frames_done;
    for (int i = 0; i < 10; i++) begin
      bus_write(8'($urandom_range(0, 255)), 1'b0, $sformatf("wrap_error_%0d", i));
      bus_idle();
      repeat (38) @(negedge clk);
    end
    wait_frames(f0 + 10, 120, "wrap_frames");
    checks++;
    if (exp_q.size() != 0 || frames_done != f0 + 10)
      $display("[TB] FAIL wrap_all_sent: frames=%0d pending=%0d, required 10 and 0",
               frames_done - f0, exp_q.size());
    else
      passes++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_overflow();
    test_read_unselected();
    test_reset_mid_frame();
    test_pointer_wrap();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
